// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers used by the pooling stages.
package cnn_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_FILTER = 16;

  typedef logic signed [DATA_W-1:0] data_t;

  // One pixel across all filter channels; index [ch] selects a channel word.
  typedef logic [NUM_FILTER-1:0][DATA_W-1:0] pix_t;

  // Signed maximum of two Q16.16 words; ties return either (equal) operand.
  function automatic data_t smax(input data_t a, input data_t b);
    return (a >= b) ? a : b;
  endfunction

  // Clamp negative values to zero.
  function automatic data_t relu(input data_t a);
    return a[DATA_W-1] ? '0 : a;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Row buffer holding horizontal maxima of the even row for the odd row to consume.
module pool_line_buf #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 512,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_c
);

  // Contents need no reset: every entry is rewritten on an even row before it is read.
  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Combinational read keeps the pooled result one cycle behind the accepting edge.
  assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/relu_maxpool_16ch.sv
// Streaming ReLU + 2x2/stride-2 max-pool over 16 parallel 32-bit channels.
module relu_maxpool_16ch
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned HEIGHT  = 8,
  parameter int unsigned FILTER  = 16,
  parameter int unsigned RELU_EN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in0,  data_in1,  data_in2,  data_in3,
  input  logic [DATA_W-1:0] data_in4,  data_in5,  data_in6,  data_in7,
  input  logic [DATA_W-1:0] data_in8,  data_in9,  data_in10, data_in11,
  input  logic [DATA_W-1:0] data_in12, data_in13, data_in14, data_in15,
  output logic [DATA_W-1:0] data_out0,  data_out1,  data_out2,  data_out3,
  output logic [DATA_W-1:0] data_out4,  data_out5,  data_out6,  data_out7,
  output logic [DATA_W-1:0] data_out8,  data_out9,  data_out10, data_out11,
  output logic [DATA_W-1:0] data_out12, data_out13, data_out14, data_out15,
  output logic              valid_out,
  output logic              done_img
);

  localparam int unsigned CW    = $clog2(WIDTH);
  localparam int unsigned RW    = $clog2(HEIGHT);
  localparam int unsigned DEPTH = WIDTH / 2;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PIX_W = NUM_FILTER * DATA_W;

  // The port list fixes the lane count.
  if (FILTER != NUM_FILTER) begin : g_filter_check
    $error("relu_maxpool_16ch: FILTER must be %0d", NUM_FILTER);
  end

  pix_t          din;
  pix_t          hold_q, hold_d;
  pix_t          hmax, lb_rdata, pool_max, pool_d;
  pix_t          dout_q, dout_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          last_col, last_row, lb_we, fire;
  logic [AW-1:0] lb_addr;

  assign din = {data_in15, data_in14, data_in13, data_in12, data_in11, data_in10, data_in9, data_in8,
                data_in7,  data_in6,  data_in5,  data_in4,  data_in3,  data_in2,  data_in1,  data_in0};

  assign last_col = (col_q == CW'(WIDTH - 1));
  assign last_row = (row_q == RW'(HEIGHT - 1));
  assign lb_we    = valid_in & col_q[0] & ~row_q[0];
  assign fire     = valid_in & col_q[0] &  row_q[0];
  assign lb_addr  = AW'(col_q >> 1);

  pool_line_buf #(
    .DEPTH  (DEPTH),
    .WORD_W (PIX_W)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (hmax),
    .raddr_i (lb_addr),
    .rdata_c (lb_rdata)
  );

  // Per-channel compare lanes: horizontal max, vertical max, optional clamp.
  for (genvar ch = 0; ch < NUM_FILTER; ch++) begin : g_lane
    assign hmax[ch]     = smax(hold_q[ch], din[ch]);
    assign pool_max[ch] = smax(lb_rdata[ch], hmax[ch]);
    assign pool_d[ch]   = (RELU_EN != 0) ? relu(pool_max[ch]) : pool_max[ch];
  end

  // Raster position advances only on accepted pixels.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Hold the even-column pixel; emit a pooled pixel on the odd-row/odd-col input.
  always_comb begin
    hold_d  = hold_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (valid_in && !col_q[0]) hold_d = din;
    if (fire) begin
      dout_d  = pool_d;
      valid_d = 1'b1;
      done_d  = last_col & last_row;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data_out0  = dout_q[0];
  assign data_out1  = dout_q[1];
  assign data_out2  = dout_q[2];
  assign data_out3  = dout_q[3];
  assign data_out4  = dout_q[4];
  assign data_out5  = dout_q[5];
  assign data_out6  = dout_q[6];
  assign data_out7  = dout_q[7];
  assign data_out8  = dout_q[8];
  assign data_out9  = dout_q[9];
  assign data_out10 = dout_q[10];
  assign data_out11 = dout_q[11];
  assign data_out12 = dout_q[12];
  assign data_out13 = dout_q[13];
  assign data_out14 = dout_q[14];
  assign data_out15 = dout_q[15];
  assign valid_out  = valid_q;
  assign done_img   = done_q;

endmodule

// File: tb/tb_relu_maxpool_16ch.sv
// Bench for relu_maxpool_16ch: a 4x4 ReLU instance and an 8x8 pass-through instance
// checked every cycle against a window-level reference model.
module tb_relu_maxpool_16ch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vin  [2];
  logic [31:0] din  [2][16];
  logic [31:0] dout [2][16];
  logic        vout [2];
  logic        done [2];

  int checks = 0;
  int errors = 0;
  int prints = 0;

  always #5 clk = ~clk;

  function automatic int wd(int g);
    return (g == 0) ? 4 : 8;
  endfunction

  relu_maxpool_16ch #(.WIDTH(4), .HEIGHT(4), .FILTER(16), .RELU_EN(1)) u4 (
    .clk(clk), .resetn(resetn), .valid_in(vin[0]),
    .data_in0(din[0][0]), .data_in1(din[0][1]), .data_in2(din[0][2]), .data_in3(din[0][3]),
    .data_in4(din[0][4]), .data_in5(din[0][5]), .data_in6(din[0][6]), .data_in7(din[0][7]),
    .data_in8(din[0][8]), .data_in9(din[0][9]), .data_in10(din[0][10]), .data_in11(din[0][11]),
    .data_in12(din[0][12]), .data_in13(din[0][13]), .data_in14(din[0][14]), .data_in15(din[0][15]),
    .data_out0(dout[0][0]), .data_out1(dout[0][1]), .data_out2(dout[0][2]), .data_out3(dout[0][3]),
    .data_out4(dout[0][4]), .data_out5(dout[0][5]), .data_out6(dout[0][6]), .data_out7(dout[0][7]),
    .data_out8(dout[0][8]), .data_out9(dout[0][9]), .data_out10(dout[0][10]), .data_out11(dout[0][11]),
    .data_out12(dout[0][12]), .data_out13(dout[0][13]), .data_out14(dout[0][14]), .data_out15(dout[0][15]),
    .valid_out(vout[0]), .done_img(done[0]));

  relu_maxpool_16ch #(.WIDTH(8), .HEIGHT(8), .FILTER(16), .RELU_EN(0)) u8 (
    .clk(clk), .resetn(resetn), .valid_in(vin[1]),
    .data_in0(din[1][0]), .data_in1(din[1][1]), .data_in2(din[1][2]), .data_in3(din[1][3]),
    .data_in4(din[1][4]), .data_in5(din[1][5]), .data_in6(din[1][6]), .data_in7(din[1][7]),
    .data_in8(din[1][8]), .data_in9(din[1][9]), .data_in10(din[1][10]), .data_in11(din[1][11]),
    .data_in12(din[1][12]), .data_in13(din[1][13]), .data_in14(din[1][14]), .data_in15(din[1][15]),
    .data_out0(dout[1][0]), .data_out1(dout[1][1]), .data_out2(dout[1][2]), .data_out3(dout[1][3]),
    .data_out4(dout[1][4]), .data_out5(dout[1][5]), .data_out6(dout[1][6]), .data_out7(dout[1][7]),
    .data_out8(dout[1][8]), .data_out9(dout[1][9]), .data_out10(dout[1][10]), .data_out11(dout[1][11]),
    .data_out12(dout[1][12]), .data_out13(dout[1][13]), .data_out14(dout[1][14]), .data_out15(dout[1][15]),
    .valid_out(vout[1]), .done_img(done[1]));

  // Reference model: store each accepted pixel in a frame; when a window's last
  // pixel arrives, the expected output is the signed max of its four pixels.
  int          pidx [2];
  int          img  [2][8][8][16];
  logic        ev   [2];
  logic        ed   [2];
  logic [31:0] eo   [2][16];

  function automatic logic [31:0] pool_ref(int g, int k, int p);
    int w, r, c, m;
    int v [4];
    w = wd(g);
    r = p / w;
    c = p % w;
    v[0] = img[g][r-1][c-1][k];
    v[1] = img[g][r-1][c][k];
    v[2] = img[g][r][c-1][k];
    v[3] = int'(din[g][k]);
    m = v[0];
    for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
    if (g == 0 && m < 0) m = 0;
    return 32'(m);
  endfunction

  always @(posedge clk or negedge resetn) begin : model
    if (!resetn) begin
      for (int g = 0; g < 2; g++) begin
        pidx[g] <= 0;
        ev[g]   <= 1'b0;
        ed[g]   <= 1'b0;
        for (int k = 0; k < 16; k++) eo[g][k] <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        ev[g] <= 1'b0;
        ed[g] <= 1'b0;
        if (vin[g]) begin
          for (int k = 0; k < 16; k++)
            img[g][pidx[g] / wd(g)][pidx[g] % wd(g)][k] <= int'(din[g][k]);
          if (((pidx[g] / wd(g)) % 2 == 1) && ((pidx[g] % wd(g)) % 2 == 1)) begin
            for (int k = 0; k < 16; k++) eo[g][k] <= pool_ref(g, k, pidx[g]);
            ev[g] <= 1'b1;
            ed[g] <= (pidx[g] == wd(g) * wd(g) - 1);
          end
          pidx[g] <= (pidx[g] + 1) % (wd(g) * wd(g));
        end
      end
    end
  end

  logic [31:0] log_ch0 [$];
  logic [31:0] log_ch1 [$];
  logic        log_done[$];

  task automatic fail_line(string nm, int g, logic [31:0] got, logic [31:0] expv);
    errors++;
    if (prints < 40) begin
      prints++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, g, got, expv, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  task automatic compare();
    for (int g = 0; g < 2; g++) begin
      int bad;
      checks++;
      if (vout[g] !== ev[g]) fail_line("valid_out", g, 32'(vout[g]), 32'(ev[g]));
      checks++;
      if (done[g] !== ed[g]) fail_line("done_img", g, 32'(done[g]), 32'(ed[g]));
      checks++;
      bad = -1;
      for (int k = 0; k < 16; k++) if (bad < 0 && dout[g][k] !== eo[g][k]) bad = k;
      if (bad >= 0) fail_line($sformatf("data_out%0d", bad), g, dout[g][bad], eo[g][bad]);
    end
    if (vout[0] === 1'b1 || vout[1] === 1'b1) begin
      log_ch0.push_back(vout[0] ? dout[0][0] : dout[1][0]);
      log_ch1.push_back(vout[0] ? dout[0][1] : dout[1][1]);
      log_done.push_back(vout[0] ? done[0] : done[1]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(int n);
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic lit(string nm, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) fail_line(nm, -1, got, expv);
  endtask

  task automatic lit_pulse(string nm, int idx, logic [31:0] e0, logic [31:0] e1, logic ed_v);
    if (idx >= log_ch0.size()) begin
      lit({nm, "_missing"}, 32'(log_ch0.size()), 32'(idx + 1));
    end else begin
      lit({nm, "_ch0"}, log_ch0[idx], e0);
      lit({nm, "_ch1"}, log_ch1[idx], e1);
      lit({nm, "_done"}, 32'(log_done[idx]), 32'(ed_v));
    end
  endtask

  task automatic clear_log();
    log_ch0.delete();
    log_ch1.delete();
    log_done.delete();
  endtask

  // Pixel generators: 0 index+100k, 1 negated, 2 window-corner extremes, 3 random.
  function automatic logic [31:0] gen(int pat, int g, int p, int k);
    int w, r, c, win, corner;
    logic hit;
    w = wd(g);
    r = p / w;
    c = p % w;
    win = (r / 2) * (w / 2) + c / 2;
    corner = (r % 2) * 2 + (c % 2);
    hit = (corner == (win + k) % 4);
    case (pat)
      0:       return 32'(p + 100 * k);
      1:       return 32'(-(p + 100 * k));
      2:       return (k % 2 == 0) ? (hit ? 32'h7FFF_FFFF : 32'h8000_0000)
                                   : (hit ? 32'hFFFF_FFFB : 32'h8000_0000);
      default: return 32'($urandom());
    endcase
  endfunction

  // gap: 0 none, 1 alternate idle cycles, 2 random idle cycles.
  task automatic send_image(int g, int pat, int gap, int npix);
    for (int p = 0; p < npix; p++) begin
      for (int k = 0; k < 16; k++) din[g][k] = gen(pat, g, p, k);
      vin[g] = 1'b1;
      tick();
      vin[g] = 1'b0;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        for (int k = 0; k < 16; k++) din[g][k] = 32'($urandom());
        tick();
      end
    end
  endtask

  task automatic pulse_reset();
    #1 resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    for (int g = 0; g < 2; g++) begin
      vin[g] = 1'b0;
      for (int k = 0; k < 16; k++) din[g][k] = '0;
    end
    repeat (3) tick();
    lit("reset_valid", 32'(vout[0]), 32'd0);
    lit("reset_done", 32'(done[1]), 32'd0);
    lit("reset_data", dout[1][7], 32'd0);
    resetn = 1'b1;
    tick();

    // 4x4 index pattern, valid every cycle.
    clear_log();
    send_image(0, 0, 0, 16);
    idle(3);
    lit("t1_count", 32'(log_ch0.size()), 32'd4);
    lit_pulse("t1_p0", 0, 32'd5,  32'd105, 1'b0);
    lit_pulse("t1_p1", 1, 32'd7,  32'd107, 1'b0);
    lit_pulse("t1_p2", 2, 32'd13, 32'd113, 1'b0);
    lit_pulse("t1_p3", 3, 32'd15, 32'd115, 1'b1);

    // Negated image through the ReLU instance clamps to zero.
    clear_log();
    send_image(0, 1, 0, 16);
    idle(3);
    lit("t2_count", 32'(log_ch0.size()), 32'd4);
    for (int i = 0; i < 4; i++) lit_pulse("t2", i, 32'd0, 32'd0, i == 3);

    // Same image with valid toggling.
    clear_log();
    send_image(0, 0, 1, 16);
    idle(3);
    lit("t3_count", 32'(log_ch0.size()), 32'd4);
    lit_pulse("t3_p0", 0, 32'd5,  32'd105, 1'b0);
    lit_pulse("t3_p3", 3, 32'd15, 32'd115, 1'b1);

    // Extremes at each window corner; odd channels clamp the -5 winner.
    clear_log();
    send_image(0, 2, 2, 16);
    idle(3);
    for (int i = 0; i < 4; i++) lit_pulse("t4", i, 32'h7FFF_FFFF, 32'd0, i == 3);

    // Random images with random gaps.
    repeat (3) send_image(0, 3, 2, 16);
    idle(3);

    // Two 8x8 images back-to-back, no relu.
    clear_log();
    send_image(1, 1, 0, 64);
    send_image(1, 3, 0, 64);
    idle(3);
    lit("t6_count", 32'(log_ch0.size()), 32'd32);
    lit_pulse("t6_p0", 0, 32'd0,           32'hFFFF_FF9C, 1'b0);
    lit_pulse("t6_p1", 1, 32'hFFFF_FFFE,   32'hFFFF_FF9A, 1'b0);
    lit_pulse("t6_p3", 3, 32'hFFFF_FFFA,   32'hFFFF_FF96, 1'b0);
    if (log_done.size() == 32) begin
      lit("t6_done16", 32'(log_done[15]), 32'd1);
      lit("t6_done32", 32'(log_done[31]), 32'd1);
      lit("t6_done_mid", 32'(log_done[14]), 32'd0);
    end

    // Reset after 10 pixels, then a full extremes image.
    send_image(1, 3, 0, 10);
    pulse_reset();
    clear_log();
    send_image(1, 2, 0, 64);
    idle(3);
    lit("t7_count", 32'(log_ch0.size()), 32'd16);
    lit_pulse("t7_p0",  0,  32'h7FFF_FFFF, 32'hFFFF_FFFB, 1'b0);
    lit_pulse("t7_p15", 15, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 1'b1);

    // Random gaps on the 8x8 instance, then a mid-image reset on both.
    send_image(1, 3, 2, 64);
    send_image(0, 3, 0, 7);
    pulse_reset();
    send_image(0, 0, 0, 16);
    send_image(1, 2, 2, 64);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_maxpool_16ch.md
# relu_maxpool_16ch

Streaming ReLU + 2×2/stride-2 max-pool stage directly downstream of the 8-channel-in / 16-filter 3-D convolution. It consumes the convolution's 16 parallel 32-bit output words per pixel, in raster order, and emits one pooled pixel (16 words) per 2×2 window. Output images are WIDTH/2 × HEIGHT/2 and feed the next convolution layer's data inputs.

## Interface
Parameters:
- WIDTH, 8, input image width in pixels; must be even and ≥2.
- HEIGHT, 8, input image height in pixels; must be even and ≥2.
- FILTER, 16, channel count; fixed at 16 by the port list.
- RELU_EN, 1, 1 clamps outputs at 0, 0 passes the raw max.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- valid_in  in  1  data_in0..15 carry one input pixel this cycle; gaps are allowed.
- data_in0 … data_in15  in  32 each  channel values, signed two's complement (Q16.16).
- data_out0 … data_out15  out  32 each  pooled, optionally ReLU'd values, registered.
- valid_out  out  1  one-cycle pulse per pooled pixel.
- done_img  out  1  pulse coincident with the valid_out of the last pooled pixel of an image.

## Operation
- Input position is tracked by col (0..WIDTH-1) and row (0..HEIGHT-1), advancing only on valid_in. col wraps to 0 and increments row; after row HEIGHT-1, col WIDTH-1, both return to 0.
- Even col: register the input into hold[ch].
- Odd col: hmax[ch] = signed max(hold[ch], data_in[ch]).
  - Even row: write hmax into line_buf[col>>1]. The buffer has WIDTH/2 entries of 16×32 bits.
  - Odd row: m = signed max(line_buf[col>>1], hmax). The output is m, or 0 if RELU_EN is set and m < 0. Register it to data_out and pulse valid_out.
- All comparisons are signed 32-bit. On a tie either operand may be taken, since the values are equal. No width growth occurs.
- done_img fires when the emitted pixel came from input (row HEIGHT-1, col WIDTH-1).
- The next image starts on the next valid_in with no idle cycle required; back-to-back images must pool correctly.
- data_out holds its last value between valid_out pulses.

## Timing
- Reset values: data_out* = 0, valid_out = 0, done_img = 0; col, row, hold and the buffer read pointer are cleared. line_buf contents are don't-care, because every even row rewrites each entry before it is read.
- Latency: valid_out rises exactly 1 cycle after the valid_in edge that accepts an odd-row/odd-col pixel.
- Throughput: accepts valid_in every cycle; there is no backpressure, and the downstream stage must accept every pulse.
- Output rate: WIDTH·HEIGHT/4 valid_out pulses per image; done_img occurs exactly once per image.
- Reset mid-image: all position state is discarded; the next valid_in is treated as pixel (0,0), and no partial output is emitted.
- valid_in low: col, row, hold and line_buf are frozen, and valid_out/done_img are 0 on the following cycle.
- line_buf: a write and a read never target the same entry in the same cycle (even rows write, odd rows read). The read is combinational or uses a 1-cycle-early registered address; either way the 1-cycle output latency must hold.

## Structure
- Shared package `cnn_pkg` holds:
  - DATA_W = 32 and NUM_FILTER = 16;
  - a signed-max function and a relu function, reused by later pooling layers.
- Sub-module `pool_line_buf`: a single-port-per-cycle WIDTH/2 × (16·32) register array with write enable, write address, read address and read data. It is parameterised by depth and word width so it can map to BRAM later.
- Top level: position counters, the hold register, 16 compare lanes built in a generate loop, and the output register.

## Test plan
- WIDTH=HEIGHT=4, channel k data = pixel index + 100·k, valid every cycle → channel 0 outputs 5, 7, 13, 15; channel 1 outputs 105, 107, 113, 115; done_img is on the 4th pulse.
- Same image with all values negated, RELU_EN=1 → all 4 outputs are 0 on every channel. With RELU_EN=0 → channel 0 outputs 0, -2, -8, -10.
- Same image with valid_in toggling 1-0-1-0 → identical outputs, each valid_out exactly 1 cycle after its accepting edge.
- Two 8×8 images back-to-back with no gap → 16 outputs per image, done_img on the 16th and 32nd pulses, and no cross-image contamination.
- Reset asserted after 10 pixels of an 8×8 image, then a full image → no output from the aborted image, and 16 correct outputs for the new one.
- Max at each window corner in turn: 0x7FFFFFFF versus 0x80000000 extremes → the signed max is selected, and 0x80000000 is never reported as the maximum.
